digital_clock_core: RTL

Parametrised successor to the board-level clock: one self-contained core that holds the prescaler, the HH:MM:SS counters, debounced set buttons, 12/24-hour display mode, a counting freeze and a time-multiplexed 4-digit 7-segment driver with a blinking colon. It sits directly under the FPGA top, between the board pins (clock, buttons, switches) and the 7-segment display. It also exports the binary time fields and the 1 Hz strobe.

---
 rtl/digital_clock_core.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/digital_clock_core.sv
// Wall-clock core: prescaler, HH:MM:SS counters, debounced set buttons, 12/24h
// display conversion and a registered, time-multiplexed 4-digit 7-segment driver.
module digital_clock_core #(
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_hours_button,
  input  logic       set_minutes_button,
  input  logic       mode_12h,
  input  logic       hold,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       pm,
  output logic       tick,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

  logic [PW-1:0] pcnt;
  logic [SW-1:0] scnt;
  logic [1:0]    scan_idx;

  // Index 0 = hours button, index 1 = minutes button.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1, sync2, stable, stable_d, press;
  logic [DW-1:0] db_cnt [2];
  logic          press_h, press_m;

  assign btn_raw = {set_minutes_button, set_hours_button};
  assign press_h = press[0];
  assign press_m = press[1];
  assign pm      = (hours >= 5'd12);

  // The accepted level flips only after DEBOUNCE consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      stable    <= '0;
      stable_d  <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A minute press restarts the one-second period from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (press_m) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
      tick <= (pcnt == P_LAST);
    end
  end

  // Presses take priority over a coincident tick, whose increment is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      seconds <= '0;
      minutes <= '0;
      hours   <= '0;
    end else if (press_h || press_m) begin
      if (press_h) hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
      if (press_m) begin
        minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        seconds <= '0;
      end
    end else if (tick && !hold) begin
      if (seconds == 6'd59) begin
        seconds <= '0;
        if (minutes == 6'd59) begin
          minutes <= '0;
          hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end else begin
          minutes <= minutes + 6'd1;
        end
      end else begin
        seconds <= seconds + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scnt     <= '0;
      scan_idx <= '0;
    end else if (scnt == S_LAST) begin
      scnt     <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  logic [4:0] dh;
  logic [3:0] digit;
  logic [6:0] seg_next;
  logic [3:0] an_next;
  logic       dp_next;

  always_comb begin
    dh = hours;
    if (mode_12h) begin
      if (hours == 5'd0)       dh = 5'd12;
      else if (hours > 5'd12)  dh = hours - 5'd12;
    end
    case (scan_idx)
      2'd0:    digit = 4'(minutes % 6'd10);
      2'd1:    digit = 4'(minutes / 6'd10);
      2'd2:    digit = 4'(dh % 5'd10);
      default: digit = 4'(dh / 5'd10);
    endcase
    // Leading hour digit is blanked only in 12h mode; its anode stays active.
    seg_next = (scan_idx == 2'd3 && mode_12h && digit == 4'd0) ? 7'h7F : seg_of(digit);
    an_next  = ~(4'b0001 << scan_idx);
    dp_next  = 1'b1;
    if (scan_idx == 2'd2 && !seconds[0])      dp_next = 1'b0;
    if (scan_idx == 2'd0 && mode_12h && pm)   dp_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 7'b1000000;
      an  <= 4'b1110;
      dp  <= 1'b1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      dp  <= dp_next;
    end
  end

endmodule
